// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the memory-mapped I/O responder: register map,
// STATUS / TMR_CTRL bit positions and the default window base address.
package io_port_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0100;

  // Word index within the 32-byte window, taken from Address[4:2].
  typedef enum logic [2:0] {
    REG_PORT_OUT  = 3'd0,
    REG_PORT_IN   = 3'd1,
    REG_STATUS    = 3'd2,
    REG_TMR_LOAD  = 3'd3,
    REG_TMR_CTRL  = 3'd4,
    REG_TMR_COUNT = 3'd5,
    REG_RSVD_18   = 3'd6,
    REG_RSVD_1C   = 3'd7
  } reg_sel_e;

  localparam int STATUS_WIDTH   = 2;
  localparam int STATUS_IN_CHG  = 0;
  localparam int STATUS_TMR_EXP = 1;

  localparam int CTRL_WIDTH   = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQ_EN0 = 2;
  localparam int CTRL_IRQ_EN1 = 3;

endpackage

// File: rtl/io_port_responder_bit_synchronizer.sv
// Multi-flop synchronizer for an asynchronous bus; every bit is
// synchronized independently (callers must tolerate per-bit skew).
module bit_synchronizer #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [STAGES-1:0][WIDTH-1:0] r_stages;

  // NOTE: non-blocking assignment so each stage captures its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stages[STAGES-1];

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with
// change detection, and a down-counter timer with optional auto-reload.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int            N           = 32,
  parameter logic [N-1:0]  BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int            IN_WIDTH    = 8,
  parameter int            SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [N-1:0]        Address,
  input  logic [N-1:0]        WriteData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [N-1:0]        ReadData,
  output logic                Hit,
  output logic [N-1:0]        PortOut,
  output logic                IRQ
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]            r_port_out;
  logic [N-1:0]            r_tmr_load;
  logic [N-1:0]            r_count;
  logic [CTRL_WIDTH-1:0]   r_ctrl;
  logic [STATUS_WIDTH-1:0] r_status;
  logic [IN_WIDTH-1:0]     r_prev;
  logic                    r_irq;

  logic [IN_WIDTH-1:0]     w_sync;
  reg_sel_e                w_sel;
  logic                    w_wr;
  logic                    w_wr_load;
  logic [N-1:0]            w_count_nxt;
  logic                    w_exp_set;
  logic [STATUS_WIDTH-1:0] w_status_set;
  logic [STATUS_WIDTH-1:0] w_status_clr;
  logic [N-1:0]            w_rd_mux;
  logic                    w_unused_addr_bits;

  bit_synchronizer #(
    .WIDTH  (IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_port_in_sync (
    .clk     (clk),
    .rst_n   (reset),
    .i_async (PortIn),
    .o_sync  (w_sync)
  );

  assign Hit                = (Address[N-1:5] == BASE_ADDR[N-1:5]);
  assign w_sel              = reg_sel_e'(Address[4:2]);
  assign w_wr               = MemWrite & Hit;
  assign w_wr_load          = w_wr && (w_sel == REG_TMR_LOAD);
  assign w_unused_addr_bits = ^Address[1:0];

  // Timer next state; a TMR_LOAD write overrides decrement, expiry and reload.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    w_exp_set   = 1'b0;
    if (w_wr_load) begin
      w_count_nxt = WriteData;
    end else if (r_ctrl[CTRL_EN]) begin
      if (r_count > ONE) begin
        w_count_nxt = r_count - ONE;
      end else if (r_count == ONE) begin
        w_count_nxt = '0;
        w_exp_set   = 1'b1;
      end else if (r_ctrl[CTRL_AUTO]) begin
        w_count_nxt = r_tmr_load;
      end
    end
  end

  always_comb begin
    w_status_set                 = '0;
    w_status_set[STATUS_IN_CHG]  = (w_sync != r_prev);
    w_status_set[STATUS_TMR_EXP] = w_exp_set;
    w_status_clr                 = '0;
    if (w_wr && (w_sel == REG_STATUS)) begin
      w_status_clr = WriteData[STATUS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= '0;
      r_tmr_load <= '0;
      r_count    <= '0;
      r_ctrl     <= '0;
      r_status   <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_sel == REG_PORT_OUT)) r_port_out <= WriteData;
      if (w_wr_load)                       r_tmr_load <= WriteData;
      if (w_wr && (w_sel == REG_TMR_CTRL)) r_ctrl     <= WriteData[CTRL_WIDTH-1:0];
      r_count  <= w_count_nxt;
      // Hardware set wins over a same-cycle W1C clear.
      r_status <= w_status_set | (r_status & ~w_status_clr);
      r_prev   <= w_sync;
      r_irq    <= |(r_status & {r_ctrl[CTRL_IRQ_EN1], r_ctrl[CTRL_IRQ_EN0]});
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      REG_PORT_OUT:  w_rd_mux = r_port_out;
      REG_PORT_IN:   w_rd_mux[IN_WIDTH-1:0] = w_sync;
      REG_STATUS:    w_rd_mux[STATUS_WIDTH-1:0] = r_status;
      REG_TMR_LOAD:  w_rd_mux = r_tmr_load;
      REG_TMR_CTRL:  w_rd_mux[CTRL_WIDTH-1:0] = r_ctrl;
      REG_TMR_COUNT: w_rd_mux = r_count;
      default:       w_rd_mux = '0;
    endcase
  end

  assign ReadData = (MemRead && Hit) ? w_rd_mux : '0;
  assign PortOut  = r_port_out;
  assign IRQ      = r_irq;

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios followed by
// randomized bus traffic, all checked against a transaction-level model.
module tb_io_port_responder;

  localparam int          N    = 32;
  localparam int          INW  = 8;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h1001_0100;

  logic            clk = 1'b0;
  logic            reset;
  logic            MemWrite, MemRead;
  logic [31:0]     Address, WriteData;
  logic [INW-1:0]  PortIn;
  logic [31:0]     ReadData, PortOut;
  logic            Hit, IRQ;

  io_port_responder #(
    .N           (N),
    .BASE_ADDR   (BASE),
    .IN_WIDTH    (INW),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortOut   (PortOut),
    .IRQ       (IRQ)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state; hist[k] is the PortIn value sampled k+1 edges ago.
  logic [31:0]    m_port_out, m_load, m_count;
  logic [3:0]     m_ctrl;
  logic           m_chg, m_exp, m_irq;
  logic [INW-1:0] hist [0:S];
  logic [31:0]    last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:5] == b[31:5];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return m_port_out;
      3'd1:    return {24'h0, hist[S-1]};
      3'd2:    return {30'h0, m_exp, m_chg};
      3'd3:    return m_load;
      3'd4:    return {28'h0, m_ctrl};
      3'd5:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_port_out = 0; m_load = 0; m_count = 0; m_ctrl = 0;
    m_chg = 0; m_exp = 0; m_irq = 0;
    for (int k = 0; k <= S; k++) hist[k] = '0;
  endtask

  // One rising edge: all next values derived from the pre-edge state.
  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic        we;
    logic [2:0]  off;
    logic        chg_set, exp_set, irq_n;
    logic [31:0] cnt_n;
    logic [1:0]  clr;
    we      = wr && in_window(a);
    off     = a[4:2];
    chg_set = (hist[S-1] != hist[S]);
    exp_set = 1'b0;
    cnt_n   = m_count;
    if (we && off == 3'd3)               cnt_n = d;
    else if (m_ctrl[0] && m_count > 1)   cnt_n = m_count - 1;
    else if (m_ctrl[0] && m_count == 1) begin cnt_n = 0; exp_set = 1'b1; end
    else if (m_ctrl[0] && m_ctrl[1])     cnt_n = m_load;
    irq_n = (m_chg && m_ctrl[2]) || (m_exp && m_ctrl[3]);
    clr   = (we && off == 3'd2) ? d[1:0] : 2'b00;
    m_chg   = chg_set || (m_chg && !clr[0]);
    m_exp   = exp_set || (m_exp && !clr[1]);
    m_count = cnt_n;
    m_irq   = irq_n;
    if (we && off == 3'd0) m_port_out = d;
    if (we && off == 3'd3) m_load     = d;
    if (we && off == 3'd4) m_ctrl     = d[3:0];
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = PortIn;
  endtask

  // Drive one bus cycle from posedge+1; sample combinational outputs at negedge.
  task automatic bus(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    MemWrite = wr; MemRead = rd; Address = a; WriteData = d;
    @(negedge clk);
    check({tag, ".hit"}, {31'h0, Hit}, {31'h0, in_window(a)});
    check({tag, ".rdata"}, ReadData, rd ? model_read(a) : 32'h0);
    last_rd = ReadData;
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    check({tag, ".portout"}, PortOut, m_port_out);
    check({tag, ".irq"}, {31'h0, IRQ}, {31'h0, m_irq});
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  logic [31:0] exp3 [0:4];
  logic [31:0] exp6 [0:4];
  int          guard;
  logic [31:0] ra;

  initial begin
    exp3[0] = 3; exp3[1] = 2; exp3[2] = 1; exp3[3] = 0; exp3[4] = 3;
    exp6[0] = 2; exp6[1] = 1; exp6[2] = 0; exp6[3] = 0; exp6[4] = 0;
    reset = 1'b0; MemWrite = 0; MemRead = 0; Address = 0; WriteData = 0;
    PortIn = 8'hA5;
    model_reset();
    #2;
    check("reset.portout", PortOut, 32'h0);
    check("reset.irq", {31'h0, IRQ}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Input synchronizer latency and change detection
    bus(0, 1, BASE + 32'h04, 0, "sync0"); check("sync0.lit", last_rd, 32'h0);
    bus(0, 1, BASE + 32'h04, 0, "sync1"); check("sync1.lit", last_rd, 32'h0);
    bus(0, 1, BASE + 32'h04, 0, "sync2"); check("sync2.lit", last_rd, 32'hA5);
    bus(0, 1, BASE + 32'h08, 0, "inchg"); check("inchg.lit", last_rd, 32'h1);

    // Output port store and out-of-window load
    bus(1, 0, BASE, 32'hDEAD_BEEF, "pout");
    check("pout.lit", PortOut, 32'hDEAD_BEEF);
    MemRead = 1'b1; Address = BASE + 32'h20; #1;
    check("miss.hit", {31'h0, Hit}, 32'h0);
    check("miss.rdata", ReadData, 32'h0);
    bus(0, 1, BASE + 32'h20, 0, "miss");

    // Auto-reload timer, TMR_EXP and delayed IRQ
    bus(1, 0, BASE + 32'h10, 32'h0, "t3.ctrl0");
    bus(1, 0, BASE + 32'h08, 32'h3, "t3.clr");
    bus(1, 0, BASE + 32'h0C, 32'h3, "t3.load");
    bus(1, 0, BASE + 32'h10, 32'hB, "t3.ctrl");
    for (int k = 0; k < 5; k++) begin
      bus(0, 1, BASE + 32'h14, 0, "t3.count");
      check("t3.count.lit", last_rd, exp3[k]);
      if (k == 2) check("t3.irq_lag", {31'h0, IRQ}, 32'h0);
      if (k == 3) check("t3.irq_rise", {31'h0, IRQ}, 32'h1);
    end

    // Same-edge set beats W1C clear; later clear succeeds
    guard = 0;
    while (m_count != 1 && guard < 10) begin
      bus(0, 0, BASE, 0, "t4.wait");
      guard++;
    end
    check("t4.reach_one", m_count, 32'h1);
    bus(1, 0, BASE + 32'h08, 32'h2, "t4.w1c_race");
    bus(0, 1, BASE + 32'h08, 0, "t4.st1");
    check("t4.exp_kept", {31'h0, last_rd[1]}, 32'h1);
    bus(1, 0, BASE + 32'h08, 32'h2, "t4.w1c");
    bus(0, 1, BASE + 32'h08, 0, "t4.st2");
    check("t4.exp_clr", {31'h0, last_rd[1]}, 32'h0);

    // One-shot timer: holds 0 after expiry
    bus(1, 0, BASE + 32'h10, 32'h0, "t6.ctrl0");
    bus(1, 0, BASE + 32'h08, 32'h3, "t6.clr");
    bus(1, 0, BASE + 32'h0C, 32'h2, "t6.load");
    bus(1, 0, BASE + 32'h10, 32'h1, "t6.ctrl");
    for (int k = 0; k < 5; k++) begin
      bus(0, 1, BASE + 32'h14, 0, "t6.count");
      check("t6.count.lit", last_rd, exp6[k]);
    end
    bus(0, 1, BASE + 32'h08, 0, "t6.st");
    check("t6.exp", {31'h0, last_rd[1]}, 32'h1);

    // Asynchronous reset mid-count
    bus(1, 0, BASE + 32'h0C, 32'd10, "t5.load");
    bus(1, 0, BASE + 32'h10, 32'hD, "t5.ctrl");
    guard = 0;
    while (m_count != 5 && guard < 20) begin
      bus(0, 0, BASE, 0, "t5.wait");
      guard++;
    end
    check("t5.reach_five", m_count, 32'h5);
    MemRead = 1'b1; Address = BASE + 32'h14; #2;
    check("t5.count_pre", ReadData, 32'h5);
    check("t5.irq_pre", {31'h0, IRQ}, 32'h1);
    reset = 1'b0; #1;
    check("t5.count_rst", ReadData, 32'h0);
    check("t5.pout_rst", PortOut, 32'h0);
    check("t5.irq_rst", {31'h0, IRQ}, 32'h0);
    model_reset();
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus(0, 1, BASE + 32'h14, 0, "t5.idle0");
    bus(0, 1, BASE + 32'h14, 0, "t5.idle1");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        wr, rd;
      logic [31:0] d;
      logic [2:0]  off;
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra = BASE + 32'h20 + {27'h0, off, 2'b00};
      else                           ra = BASE + {27'h0, off, $urandom_range(0, 3) == 0 ? 2'b11 : 2'b00};
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 1) == 1);
      d  = $urandom;
      if (off == 3'd3) d = $urandom_range(0, 5);
      if ($urandom_range(0, 5) == 0) PortIn = 8'($urandom);
      bus(wr, rd, ra, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
